// File: rtl/usb_rx_decoder.sv
// USB full-speed receive front end: edge-locked bit timing, NRZI decode,
// bit unstuffing, and EOP / line-error detection on synchronized D+/D-.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int STUFF_LEN    = 6,
    parameter int IDLE_BITS    = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic dp_sync,
    input  logic dm_sync,
    output logic d_orig,
    output logic shift_enable,
    output logic eop,
    output logic rx_err,
    output logic rx_active
);

    localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ONES_W     = $clog2(STUFF_LEN + 1);
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
    localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(STUFF_LEN);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_LIMIT - 1);

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    typedef enum logic [1:0] {IDLE, RX, ERR} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   counter, counter_next;
    logic [1:0]         prev_sample, prev_sample_next;
    logic [ONES_W-1:0]  ones_cnt, ones_cnt_next;
    logic [1:0]         se0_cnt, se0_cnt_next;
    logic [IDLE_W-1:0]  idle_cnt, idle_cnt_next;
    logic               dp_prev;
    logic               d_orig_next, shift_next, eop_next, err_next;
    logic               edge_det, strobe, bit_val;
    logic [1:0]         line;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd2) ? v : v + 2'd1;
    endfunction

    assign line      = {dp_sync, dm_sync};
    assign edge_det  = (dp_sync != dp_prev);
    assign strobe    = (state == RX) && !edge_det && (counter == CNT_SAMPLE);
    assign bit_val   = (line == prev_sample);
    assign rx_active = (state == RX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            counter      <= '0;
            prev_sample  <= LINE_J;
            ones_cnt     <= '0;
            se0_cnt      <= '0;
            idle_cnt     <= '0;
            dp_prev      <= 1'b1;
            d_orig       <= 1'b1;
            shift_enable <= 1'b0;
            eop          <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            prev_sample  <= prev_sample_next;
            ones_cnt     <= ones_cnt_next;
            se0_cnt      <= se0_cnt_next;
            idle_cnt     <= idle_cnt_next;
            dp_prev      <= dp_sync;
            d_orig       <= d_orig_next;
            shift_enable <= shift_next;
            eop          <= eop_next;
            rx_err       <= err_next;
        end
    end

    always_comb begin
        state_next       = state;
        counter_next     = '0;
        prev_sample_next = prev_sample;
        ones_cnt_next    = ones_cnt;
        se0_cnt_next     = se0_cnt;
        idle_cnt_next    = '0;
        d_orig_next      = d_orig;
        shift_next       = 1'b0;
        eop_next         = 1'b0;
        err_next         = 1'b0;

        case (state)
            IDLE: begin
                // Only a J->K transition (dp falling, line K) starts a packet
                if (edge_det && line == LINE_K) begin
                    state_next       = RX;
                    prev_sample_next = LINE_J;
                    ones_cnt_next    = '0;
                    se0_cnt_next     = '0;
                end
            end
            RX: begin
                if (edge_det || counter == CNT_MAX) counter_next = '0;
                else                                counter_next = counter + 1'b1;

                if (strobe) begin
                    if (line == LINE_SE1) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else if (line == LINE_SE0) begin
                        se0_cnt_next = sat_inc2(se0_cnt);
                    end else if (se0_cnt == 2'd1) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else if (se0_cnt == 2'd2) begin
                        if (line == LINE_J) begin
                            eop_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ERR;
                        end
                    end else begin
                        prev_sample_next = line;
                        // After a full run of ones the next bit must be a stuffed zero
                        if (ones_cnt == ONES_STUFF) begin
                            if (bit_val) begin
                                err_next   = 1'b1;
                                state_next = ERR;
                            end else begin
                                ones_cnt_next = '0;
                            end
                        end else begin
                            d_orig_next   = bit_val;
                            shift_next    = 1'b1;
                            ones_cnt_next = bit_val ? ones_cnt + 1'b1 : '0;
                        end
                    end
                end
            end
            ERR: begin
                if (line == LINE_J) begin
                    if (idle_cnt == IDLE_LAST) state_next = IDLE;
                    else                       idle_cnt_next = idle_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: directed vector table, hand-timed corner sequences,
// and random packets scored against a bit-level line-decoding model.
module tb_usb_rx_decoder;

    localparam int SL = 6;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic clk = 1'b0;
    logic n_rst, dp_sync, dm_sync;
    logic d_orig, shift_enable, eop, rx_err, rx_active;

    usb_rx_decoder #(
        .CLKS_PER_BIT(8), .SAMPLE_POINT(3), .STUFF_LEN(SL), .IDLE_BITS(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .dp_sync(dp_sync), .dm_sync(dm_sync),
        .d_orig(d_orig), .shift_enable(shift_enable), .eop(eop),
        .rx_err(rx_err), .rx_active(rx_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int bitv; int at; } ev_t;  // kind: 0 shift, 1 eop, 2 err
    ev_t evq[$];
    ev_t expq[$];
    logic [1:0] sq[$];
    int         lq[$];
    logic [7:0] bq[$];
    logic [1:0] enc_level;
    int         enc_ones;
    int         excl_bad = 0;
    int         act_bad = 0;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (shift_enable) evq.push_back('{0, int'(d_orig), cyc});
            if (eop)          evq.push_back('{1, 0, cyc});
            if (rx_err)       evq.push_back('{2, 0, cyc});
            if (int'(shift_enable) + int'(eop) + int'(rx_err) > 1) excl_bad++;
            if ((eop || rx_err) && rx_active) act_bad++;
            if (shift_enable && !rx_active) act_bad++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic [1:0] s, input int n);
        dp_sync = s[1];
        dm_sync = s[0];
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic play();
        for (int i = 0; i < sq.size(); i++) hold(sq[i], lq[i]);
    endtask

    // NRZI encoder with optional bit stuffing; a 0 toggles the line
    task automatic push_bit(input bit b, input bit stuff);
        if (!b) enc_level = (enc_level == J) ? K : J;
        sq.push_back(enc_level);
        lq.push_back(8);
        enc_ones = b ? enc_ones + 1 : 0;
        if (stuff && enc_ones == SL) begin
            enc_level = (enc_level == J) ? K : J;
            sq.push_back(enc_level);
            lq.push_back(8);
            enc_ones = 0;
        end
    endtask

    task automatic build(input bit stuff);
        logic [7:0] syncb;
        logic [7:0] d;
        sq.delete();
        lq.delete();
        enc_level = J;
        enc_ones  = 0;
        syncb = 8'h80;
        for (int i = 0; i < 8; i++) push_bit(syncb[i], stuff);
        foreach (bq[n]) begin
            d = bq[n];
            for (int i = 0; i < 8; i++) push_bit(d[i], stuff);
        end
    endtask

    // 0/1: SE0,SE0,J  2: SE1  3: SE0,K  4: SE0,J  5: SE0,SE0,SE0,J
    task automatic add_eop(input int kind);
        case (kind)
            2: sq.push_back(SE1);
            3: begin sq.push_back(SE0); sq.push_back(K); end
            4: begin sq.push_back(SE0); sq.push_back(J); end
            5: begin sq.push_back(SE0); sq.push_back(SE0); sq.push_back(SE0); sq.push_back(J); end
            default: begin sq.push_back(SE0); sq.push_back(SE0); sq.push_back(J); end
        endcase
        while (lq.size() < sq.size()) lq.push_back(8);
    endtask

    // Reference: walk the per-bit line states and list the expected pulses
    task automatic model(output int eidx);
        logic [1:0] prev;
        logic [1:0] s;
        int ones, se0;
        bit b;
        expq.delete();
        prev = J; ones = 0; se0 = 0; eidx = -1;
        for (int i = 0; i < sq.size(); i++) begin
            s = sq[i];
            if (s == SE1) begin expq.push_back('{2, 0, 0}); eidx = i; break; end
            if (s == SE0) begin se0 = (se0 < 2) ? se0 + 1 : 2; continue; end
            if (se0 == 1 || (se0 == 2 && s == K)) begin expq.push_back('{2, 0, 0}); eidx = i; break; end
            if (se0 == 2) begin expq.push_back('{1, 0, 0}); break; end
            b = (s == prev);
            prev = s;
            if (ones == SL) begin
                if (b) begin expq.push_back('{2, 0, 0}); eidx = i; break; end
                ones = 0;
            end else begin
                expq.push_back('{0, int'(b), 0});
                ones = b ? ones + 1 : 0;
            end
        end
    endtask

    task automatic run_packet(input string name);
        int eidx, m;
        model(eidx);
        if (eidx >= 0) while (sq.size() > eidx + 1) begin void'(sq.pop_back()); void'(lq.pop_back()); end
        evq.delete();
        play();
        hold(J, 40);
        chk({name, "_nevents"}, evq.size(), expq.size());
        m = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_kind%0d", name, i), evq[i].kind, expq[i].kind);
            if (expq[i].kind == 0) chk($sformatf("%s_bit%0d", name, i), evq[i].bitv, expq[i].bitv);
        end
    endtask

    typedef struct { logic [7:0] data; int fault; int exp_shifts; int exp_eop; int exp_err; } vec_t;
    vec_t tbl[9];

    initial begin
        int st, ns, ne, nr, idx, nb, f;
        logic [7:0] d;
        tbl[0] = '{8'h00, 0, 16, 1, 0};
        tbl[1] = '{8'hFF, 0, 16, 1, 0};
        tbl[2] = '{8'hA5, 0, 16, 1, 0};
        tbl[3] = '{8'hFE, 0, 16, 1, 0};
        tbl[4] = '{8'hFF, 1, 13, 0, 1};
        tbl[5] = '{8'h3C, 3, 16, 0, 1};
        tbl[6] = '{8'h3C, 4, 16, 0, 1};
        tbl[7] = '{8'hC3, 5, 16, 1, 0};
        tbl[8] = '{8'h55, 2, 16, 0, 1};

        n_rst = 1'b0; dp_sync = 1'b1; dm_sync = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_d_orig", int'(d_orig), 1);
        chk("reset_shift", int'(shift_enable), 0);
        chk("reset_eop", int'(eop), 0);
        chk("reset_err", int'(rx_err), 0);
        chk("reset_active", int'(rx_active), 0);
        n_rst = 1'b1;
        hold(J, 4);
        chk("idle_active", int'(rx_active), 0);

        // Sync pattern timing: first strobe output 5 clocks after the K edge, then every 8
        bq.delete();
        build(1'b1);
        add_eop(0);
        evq.delete();
        st = cyc;
        play();
        hold(J, 30);
        chk("sync_nevents", evq.size(), 9);
        if (evq.size() >= 9) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("sync_kind%0d", i), evq[i].kind, 0);
                chk($sformatf("sync_bit%0d", i), evq[i].bitv, (i == 7) ? 1 : 0);
                chk($sformatf("sync_time%0d", i), evq[i].at - st, 5 + 8 * i);
            end
            chk("sync_eop", evq[8].kind, 1);
        end

        // Asynchronous reset mid-packet, between strobes
        hold(K, 7);
        chk("pre_reset_active", int'(rx_active), 1);
        chk("pre_reset_d_orig", int'(d_orig), 0);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_d_orig", int'(d_orig), 1);
        chk("midrst_active", int'(rx_active), 0);
        chk("midrst_pulses", int'(shift_enable) + int'(eop) + int'(rx_err), 0);
        dp_sync = 1'b1; dm_sync = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_rst = 1'b1;
        evq.delete();
        hold(J, 12);
        chk("post_reset_active", int'(rx_active), 0);
        chk("post_reset_events", evq.size(), 0);

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            bq.delete();
            bq.push_back(tbl[v].data);
            build(tbl[v].fault != 1);
            add_eop(tbl[v].fault);
            evq.delete();
            play();
            hold(J, 40);
            ns = 0; ne = 0; nr = 0;
            d = tbl[v].data;
            foreach (evq[i]) begin
                if (evq[i].kind == 0) begin
                    if (ns < tbl[v].exp_shifts)
                        chk($sformatf("vec%0d_bit%0d", v, ns), evq[i].bitv,
                            (ns < 8) ? int'(ns == 7) : int'(d[ns - 8]));
                    ns++;
                end else if (evq[i].kind == 1) ne++;
                else nr++;
            end
            chk($sformatf("vec%0d_shifts", v), ns, tbl[v].exp_shifts);
            chk($sformatf("vec%0d_eop", v), ne, tbl[v].exp_eop);
            chk($sformatf("vec%0d_err", v), nr, tbl[v].exp_err);
        end

        // Stuff error: seven consecutive ones, then recovery needs 16 clocks of J
        bq.delete();
        bq.push_back(8'h3F);
        build(1'b0);
        while (sq.size() > 14) begin void'(sq.pop_back()); void'(lq.pop_back()); end
        evq.delete();
        st = cyc;
        play();
        chk("stufferr_nevents", evq.size(), 14);
        if (evq.size() == 14) begin
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("stufferr_kind%0d", i), evq[i].kind, 0);
                chk($sformatf("stufferr_bit%0d", i), evq[i].bitv, (i >= 7) ? 1 : 0);
            end
            chk("stufferr_err", evq[13].kind, 2);
            chk("stufferr_time", evq[13].at - st, 5 + 13 * 8);
        end
        chk("stufferr_active", int'(rx_active), 0);
        evq.delete();
        hold(K, 8);
        hold(J, 15);
        hold(K, 8);
        chk("err_short_idle_active", int'(rx_active), 0);
        chk("err_short_idle_events", evq.size(), 0);
        hold(J, 16);
        bq.delete();
        bq.push_back(8'h00);
        build(1'b1);
        add_eop(0);
        run_packet("recover");

        // Bit-length jitter: 7/9 clock bits through sync and data
        bq.delete();
        bq.push_back(8'h00);
        build(1'b1);
        add_eop(0);
        for (int i = 0; i < 16; i++) lq[i] = (i % 2 == 0) ? 7 : 9;
        run_packet("jitter");

        // SE1 mid-packet
        bq.delete();
        bq.push_back(8'hB7);
        build(1'b1);
        add_eop(0);
        sq[11] = SE1;
        run_packet("se1_mid");
        ns = 0;
        foreach (evq[i]) if (evq[i].kind == 0) ns++;
        chk("se1_mid_shifts", ns, 11);
        if (evq.size() > 0) chk("se1_mid_last", evq[evq.size() - 1].kind, 2);
        else chk("se1_mid_last", -1, 2);

        // Random packets, with and without faults
        for (int n = 0; n < 40; n++) begin
            bq.delete();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) bq.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            f = $urandom_range(0, 5);
            build(f != 1);
            add_eop((f == 2) ? 0 : f);
            if (f == 2) begin
                idx = $urandom_range(8, sq.size() - 1);
                sq[idx] = SE1;
            end
            run_packet($sformatf("rnd%0d", n));
        end

        chk("pulse_exclusive", excl_bad, 0);
        chk("active_vs_pulses", act_bad, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
